// File: rtl/pipe_stage_ctrl.sv
// Valid/allow_in handshake control and inter-stage bus latches for an N-stage
// in-order pipeline, with partial (younger-only) flush and performance counters.
module pipe_stage_ctrl #(
    parameter int STAGES = 5,
    parameter int BUS_W  = 64,
    parameter int KEEP_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [STAGES-1:0]            over,
    input  logic [(STAGES-1)*BUS_W-1:0]  bus_in,
    input  logic                         flush,
    input  logic [3:0]                   flush_src,
    output logic [STAGES-1:0]            valid,
    output logic [STAGES-1:0]            allow_in,
    output logic                         next_fetch,
    output logic [(STAGES-1)*BUS_W-1:0]  bus_r,
    output logic [STAGES*CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]             retire_cnt
);

    localparam int               L        = STAGES - 1;
    localparam logic [3:0]       LAST_IDX = 4'(STAGES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [BUS_W-1:0] make_keep_mask(input int keep);
        logic [BUS_W-1:0] m;
        m = '0;
        for (int b = 0; b < BUS_W; b++) begin
            m[b] = (b < keep);
        end
        return m;
    endfunction

    // Low bits (the PC) survive a flush so the squashed slot stays traceable.
    localparam logic [BUS_W-1:0] KEEP_MASK = make_keep_mask(KEEP_W);

    logic [STAGES-1:0]            valid_r;
    logic [STAGES-1:0]            allow_in_s;
    logic                         allow_chain_s;
    logic [3:0]                   flush_stage_s;
    logic [STAGES-1:0]            flush_clr_s;
    logic [STAGES-1:0]            go_s;
    logic [STAGES-2:0]            adv_s;
    logic [STAGES-1:0]            stall_inc_s;
    logic                         retire_inc_s;
    logic [STAGES-2:0][BUS_W-1:0] bus_in_s;
    logic [STAGES-2:0][BUS_W-1:0] latch_r;
    logic [STAGES-1:0][CNT_W-1:0] stall_r;
    logic [CNT_W-1:0]             retire_r;

    assign bus_in_s   = bus_in;
    assign bus_r      = latch_r;
    assign stall_cnt  = stall_r;
    assign retire_cnt = retire_r;
    assign valid      = valid_r;
    assign allow_in   = allow_in_s;
    assign next_fetch = allow_in_s[0];

    // Decode the flushing stage; an out-of-range source squashes everything.
    always_comb begin
        flush_stage_s = LAST_IDX;
        flush_clr_s   = '0;
        if ((flush_src != 4'd0) && (flush_src <= LAST_IDX)) begin
            flush_stage_s = flush_src;
        end else begin
            flush_stage_s = LAST_IDX;
        end
        for (int i = 0; i < STAGES; i++) begin
            flush_clr_s[i] = flush & (4'(i) <= flush_stage_s);
        end
    end

    // Backpressure ripples from writeback toward fetch.
    always_comb begin
        allow_in_s    = '0;
        allow_chain_s = ~valid_r[L] | over[L];
        allow_in_s[L] = allow_chain_s;
        for (int i = L - 1; i >= 1; i--) begin
            allow_chain_s = ~valid_r[i] | (over[i] & allow_chain_s);
            allow_in_s[i] = allow_chain_s;
        end
        allow_in_s[0] = (over[0] & allow_chain_s) | flush;
    end

    // Per-stage advance and stall/retire events.
    always_comb begin
        go_s        = '0;
        adv_s       = '0;
        stall_inc_s = '0;
        for (int i = 0; i < L; i++) begin
            go_s[i]        = over[i] & allow_in_s[i+1];
            stall_inc_s[i] = valid_r[i] & ~flush_clr_s[i] & ~go_s[i];
        end
        go_s[L]        = over[L];
        stall_inc_s[L] = valid_r[L] & ~over[L];
        adv_s[0]       = go_s[0];
        for (int j = 1; j < L; j++) begin
            adv_s[j] = valid_r[j] & go_s[j];
        end
        retire_inc_s = valid_r[L] & over[L];
    end

    // Stage valid bits; fetch becomes valid on the first edge after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= '0;
        end else begin
            valid_r[0] <= 1'b1;
            for (int i = 1; i < STAGES; i++) begin
                if (flush_clr_s[i]) begin
                    valid_r[i] <= 1'b0;
                end else if (allow_in_s[i]) begin
                    valid_r[i] <= over[i-1] & valid_r[i-1];
                end else begin
                    valid_r[i] <= valid_r[i];
                end
            end
        end
    end

    // Inter-stage bus latches; slice j feeds stage j+1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latch_r <= '0;
        end else begin
            for (int j = 0; j < L; j++) begin
                if (flush_clr_s[j+1]) begin
                    latch_r[j] <= bus_in_s[j] & KEEP_MASK;
                end else if (adv_s[j]) begin
                    latch_r[j] <= bus_in_s[j];
                end else begin
                    latch_r[j] <= latch_r[j];
                end
            end
        end
    end

    // Free-running wrap-around performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_r  <= '0;
            retire_r <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (stall_inc_s[i]) begin
                    stall_r[i] <= stall_r[i] + CNT_ONE;
                end else begin
                    stall_r[i] <= stall_r[i];
                end
            end
            if (retire_inc_s) begin
                retire_r <= retire_r + CNT_ONE;
            end else begin
                retire_r <= retire_r;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Scoreboard bench for pipe_stage_ctrl: stimulus queues cycle-tagged expected
// values, a negedge monitor pops and compares them against the DUT outputs.
module tb_pipe_stage_ctrl;

    localparam int S  = 5;
    localparam int BW = 16;
    localparam int KW = 4;
    localparam int CW = 4;

    localparam int K_VALID  = 0;
    localparam int K_ALLOW  = 1;
    localparam int K_NEXTF  = 2;
    localparam int K_BUS    = 3;
    localparam int K_STALL  = 4;
    localparam int K_RETIRE = 5;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [S-1:0]          over;
    logic [(S-1)*BW-1:0]   bus_in;
    logic                  flush;
    logic [3:0]            flush_src;
    logic [S-1:0]          valid;
    logic [S-1:0]          allow_in;
    logic                  next_fetch;
    logic [(S-1)*BW-1:0]   bus_r;
    logic [S*CW-1:0]       stall_cnt;
    logic [CW-1:0]         retire_cnt;

    logic [BW-1:0]         src0;
    logic                  ovr3_en;
    logic [BW-1:0]         ovr3_val;

    int cyc = 0;
    int sc = 0;
    int total = 0;
    int bad = 0;
    logic done = 1'b0;

    typedef struct {
        int          due;
        int          kind;
        int          idx;
        logic [31:0] val;
        int          scen;
    } exp_t;

    exp_t sb[$];

    pipe_stage_ctrl #(.STAGES(S), .BUS_W(BW), .KEEP_W(KW), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .over       (over),
        .bus_in     (bus_in),
        .flush      (flush),
        .flush_src  (flush_src),
        .valid      (valid),
        .allow_in   (allow_in),
        .next_fetch (next_fetch),
        .bus_r      (bus_r),
        .stall_cnt  (stall_cnt),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stand-in: each stage passes its latched bus straight on.
    always_comb begin
        bus_in = '0;
        bus_in[0 +: BW] = src0;
        for (int j = 1; j < S - 1; j++) begin
            bus_in[j*BW +: BW] = bus_r[(j-1)*BW +: BW];
        end
        if (ovr3_en) begin
            bus_in[3*BW +: BW] = ovr3_val;
        end
    end

    function automatic string kind_name(input int k);
        case (k)
            K_VALID:  return "valid";
            K_ALLOW:  return "allow_in";
            K_NEXTF:  return "next_fetch";
            K_BUS:    return "bus_r";
            K_STALL:  return "stall_cnt";
            K_RETIRE: return "retire_cnt";
            default:  return "unknown";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int k, input int idx);
        case (k)
            K_VALID:  return 32'(valid);
            K_ALLOW:  return 32'(allow_in);
            K_NEXTF:  return 32'(next_fetch);
            K_BUS:    return 32'(bus_r[idx*BW +: BW]);
            K_STALL:  return 32'(stall_cnt[idx*CW +: CW]);
            K_RETIRE: return 32'(retire_cnt);
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_now(input int k, input int idx, input logic [31:0] v);
        exp_t e;
        e.due  = cyc;
        e.kind = k;
        e.idx  = idx;
        e.val  = v;
        e.scen = sc;
        sb.push_back(e);
    endtask

    // Monitor: compare every expectation that falls due this cycle.
    always @(negedge clk) begin
        int i;
        logic [31:0] a;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due <= cyc) begin
                a = actual(sb[i].kind, sb[i].idx);
                total = total + 1;
                if ((sb[i].due < cyc) || (a !== sb[i].val)) begin
                    bad = bad + 1;
                    $display("FAIL sc%0d %s[%0d] cycle=%0d got=%h exp=%h",
                             sb[i].scen, kind_name(sb[i].kind), sb[i].idx,
                             cyc, a, sb[i].val);
                end
                sb.delete(i);
            end else begin
                i = i + 1;
            end
        end
        if (done && (sb.size() != 0)) begin
            total = total + sb.size();
            bad   = bad + sb.size();
            $display("FAIL leftover: %0d expectations never compared", sb.size());
            sb.delete();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        reset   = 1'b1;
        over    = '0;
        flush   = 1'b0;
        ovr3_en = 1'b0;
        src0    = '0;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic drive(input int k);
        over      = '1;
        flush     = 1'b0;
        flush_src = 4'd0;
        src0      = 16'h1111 + 16'(k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        over      = '0;
        flush     = 1'b0;
        flush_src = 4'd0;
        src0      = '0;
        ovr3_en   = 1'b0;
        ovr3_val  = '0;

        // Reset state
        sc = 0;
        step();
        expect_now(K_VALID, 0, 32'h0);
        expect_now(K_ALLOW, 0, 32'h1E);
        expect_now(K_NEXTF, 0, 32'h0);
        expect_now(K_BUS, 3, 32'h0);
        expect_now(K_RETIRE, 0, 32'h0);

        // Fill with everything finishing, then stall stage 2 for 3 cycles
        sc = 1;
        restart();
        for (int k = 0; k < 12; k++) begin
            drive(k);
            if (k >= 8 && k <= 10) over[2] = 1'b0;
            if (k == 0) begin
                expect_now(K_VALID, 0, 32'h01);
                expect_now(K_NEXTF, 0, 32'h1);
            end
            if (k == 4) begin
                expect_now(K_VALID, 0, 32'h1F);
                expect_now(K_BUS, 3, 32'h1111);
                expect_now(K_RETIRE, 0, 32'h0);
            end
            if (k == 5) begin
                expect_now(K_RETIRE, 0, 32'h1);
                expect_now(K_BUS, 3, 32'h1112);
            end
            if (k == 7) begin
                expect_now(K_BUS, 0, 32'h1117);
                expect_now(K_STALL, 2, 32'h0);
            end
            if (k == 8) begin
                expect_now(K_ALLOW, 0, 32'h18);
                expect_now(K_NEXTF, 0, 32'h0);
                expect_now(K_RETIRE, 0, 32'h4);
            end
            if (k == 9) begin
                expect_now(K_VALID, 0, 32'h17);
                expect_now(K_RETIRE, 0, 32'h5);
            end
            if (k == 10) expect_now(K_VALID, 0, 32'h07);
            if (k == 11) begin
                expect_now(K_STALL, 2, 32'h3);
                expect_now(K_STALL, 0, 32'h3);
                expect_now(K_STALL, 3, 32'h0);
                expect_now(K_BUS, 0, 32'h1118);
                expect_now(K_BUS, 1, 32'h1117);
                expect_now(K_RETIRE, 0, 32'h6);
                expect_now(K_VALID, 0, 32'h07);
            end
            step();
        end

        // Flush from writeback with debug-bit retention, then an out-of-range full flush
        sc = 3;
        restart();
        for (int k = 0; k < 11; k++) begin
            drive(k);
            ovr3_en = 1'b0;
            if (k == 4) begin
                flush     = 1'b1;
                flush_src = 4'd4;
                ovr3_en   = 1'b1;
                ovr3_val  = 16'hABCD;
                expect_now(K_NEXTF, 0, 32'h1);
                expect_now(K_VALID, 0, 32'h1F);
            end
            if (k == 5) begin
                expect_now(K_VALID, 0, 32'h01);
                expect_now(K_BUS, 3, 32'h000D);
                expect_now(K_BUS, 1, 32'h0004);
                expect_now(K_BUS, 0, 32'h0005);
                expect_now(K_RETIRE, 0, 32'h1);
            end
            if (k == 9) begin
                expect_now(K_VALID, 0, 32'h1F);
                flush     = 1'b1;
                flush_src = 4'd0;
            end
            if (k == 10) expect_now(K_VALID, 0, 32'h01);
            step();
        end

        // Partial flush from stage 2: older stages keep going
        sc = 4;
        restart();
        for (int k = 0; k < 7; k++) begin
            drive(k);
            if (k == 4) begin
                flush     = 1'b1;
                flush_src = 4'd2;
            end
            if (k == 5) begin
                expect_now(K_VALID, 0, 32'h19);
                expect_now(K_RETIRE, 0, 32'h1);
                expect_now(K_BUS, 2, 32'h1113);
                expect_now(K_BUS, 1, 32'h0004);
                expect_now(K_BUS, 0, 32'h0005);
            end
            if (k == 6) begin
                expect_now(K_VALID, 0, 32'h13);
                expect_now(K_RETIRE, 0, 32'h2);
            end
            step();
        end

        // Flush from stage 3 while stage 1 stalls: flush wins, no stall counted
        sc = 5;
        restart();
        for (int k = 0; k < 6; k++) begin
            drive(k);
            if (k == 4) begin
                over      = 5'b11101;
                flush     = 1'b1;
                flush_src = 4'd3;
                expect_now(K_ALLOW, 0, 32'h1D);
                expect_now(K_NEXTF, 0, 32'h1);
            end
            if (k == 5) begin
                expect_now(K_VALID, 0, 32'h11);
                expect_now(K_STALL, 1, 32'h0);
                expect_now(K_STALL, 0, 32'h0);
                expect_now(K_BUS, 2, 32'h0003);
            end
            step();
        end

        // Retire counter wrap, then an asynchronous mid-stream reset
        sc = 6;
        restart();
        for (int k = 0; k < 24; k++) begin
            drive(k);
            if (k == 19) expect_now(K_RETIRE, 0, 32'hF);
            if (k == 20) expect_now(K_RETIRE, 0, 32'h0);
            if (k == 21) begin
                reset = 1'b1;
                expect_now(K_VALID, 0, 32'h0);
                expect_now(K_BUS, 3, 32'h0);
                expect_now(K_BUS, 0, 32'h0);
                expect_now(K_RETIRE, 0, 32'h0);
            end
            if (k == 22) begin
                reset = 1'b0;
                expect_now(K_VALID, 0, 32'h0);
                expect_now(K_BUS, 0, 32'h0);
            end
            if (k == 23) begin
                expect_now(K_VALID, 0, 32'h01);
                expect_now(K_BUS, 0, 32'h1127);
            end
            step();
        end

        flush = 1'b0;
        step();
        done = 1'b1;
        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
